// File: rtl/universal_shift_register.sv
// universal_shift_register
//   WIDTH-bit staging register with parallel load and a multi-bit shift
//   command. A command is latched in IDLE, then `amount` single-bit shifts run
//   one per clock, left or right, with serial in/out and a busy/done handshake.
//   Optional feature macro: USR_ROTATE_EN adds the `rot` port. When the latched
//   rot is set, the outgoing bit re-enters the opposite end instead of sin.
// Ports
//   clk     clock; all state changes on posedge
//   rst     synchronous reset, active-high
//   load    parallel load request (IDLE only, wins over start)
//   din     parallel load data
//   start   shift command (IDLE only)
//   dir     0 = left (toward MSB), 1 = right; latched on start
//   amount  number of single-bit shifts; latched on start
//   sin     serial input, sampled on every shift edge
//   rot     (USR_ROTATE_EN only) rotate instead of shifting in sin; latched on start
//   q       register contents
//   sout    bit shifted out on the most recent shift edge
//   busy    high while a command is shifting
//   done    one-cycle pulse when a command completes
module universal_shift_register #(
    parameter int unsigned         WIDTH   = 8,
    parameter int unsigned         CNT_W   = 4,
    parameter logic [WIDTH-1:0]    RST_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] amount,
    input  logic             sin,
`ifdef USR_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dir_q;
    logic             fill_c;

`ifdef USR_ROTATE_EN
    logic             rot_q;

    // Bit entering the register: serial input, or the outgoing bit when rotating.
    always_comb begin
        fill_c = sin;
        if (rot_q) begin
            fill_c = dir_q ? q[0] : q[WIDTH-1];
        end
    end
`else
    // Bit entering the register is always the serial input.
    always_comb begin
        fill_c = sin;
    end
`endif

    // Command FSM, shift datapath and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= RST_VAL;
            sout  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            dir_q <= 1'b0;
`ifdef USR_ROTATE_EN
            rot_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        q <= din;
                    end else if (start) begin
                        if (amount == '0) begin
                            // Empty command completes immediately without going busy.
                            done <= 1'b1;
                        end else begin
                            dir_q <= dir;
                            cnt   <= amount;
                            state <= SHIFT;
                            busy  <= 1'b1;
`ifdef USR_ROTATE_EN
                            rot_q <= rot;
`endif
                        end
                    end
                end
                SHIFT: begin
                    if (dir_q) begin
                        q    <= {fill_c, q[WIDTH-1:1]};
                        sout <= q[0];
                    end else begin
                        q    <= {q[WIDTH-2:0], fill_c};
                        sout <= q[WIDTH-1];
                    end
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             sout;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             start;
    logic             dir;
    logic [CNT_W-1:0] amount;
    logic             sin;
`ifdef USR_ROTATE_EN
    logic             rot;
`endif
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    universal_shift_register #(
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W),
        .RST_VAL ({WIDTH{1'b1}})
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .din    (din),
        .start  (start),
        .dir    (dir),
        .amount (amount),
        .sin    (sin),
`ifdef USR_ROTATE_EN
        .rot    (rot),
`endif
        .q      (q),
        .sout   (sout),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Reference model: n single-bit shifts of q0 with a constant serial input.
    function automatic exp_t model(input logic [WIDTH-1:0] q0, input logic s0,
                                   input logic d, input int n, input logic s);
        exp_t r;
        r.q    = q0;
        r.sout = s0;
        for (int i = 0; i < n; i++) begin
            if (d) begin
                r.sout = r.q[0];
                r.q    = {s, r.q[WIDTH-1:1]};
            end else begin
                r.sout = r.q[WIDTH-1];
                r.q    = {r.q[WIDTH-2:0], s};
            end
        end
        return r;
    endfunction

    // Parallel load; returns at the negedge after the load edge.
    task automatic do_load(input logic [WIDTH-1:0] v);
        load = 1'b1;
        din  = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Issue a command; returns at the negedge after the start edge. sin stays driven.
    task automatic issue_cmd(input logic d, input logic [CNT_W-1:0] n, input logic s);
        start  = 1'b1;
        dir    = d;
        amount = n;
        sin    = s;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Wait (bounded) for done, counting cycles with busy high on the way.
    task automatic wait_done(input int max_cycles, output int busy_cycles, output bit ok);
        busy_cycles = 0;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (q !== 8'hFF) begin
            tests_failed++;
            $display("FAIL reset_q: got %h expected %h", q, 8'hFF);
        end
        tests_run++;
        if (sout !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got sout=%b busy=%b done=%b expected 1 0 0", sout, busy, done);
        end
    endtask

    task automatic test_load();
        do_load(8'hA5);
        tests_run++;
        if (q !== 8'hA5) begin
            tests_failed++;
            $display("FAIL load_q: got %h expected %h", q, 8'hA5);
        end
        // load together with start: load wins, command dropped
        load   = 1'b1;
        din    = 8'h3C;
        start  = 1'b1;
        dir    = 1'b0;
        amount = 4'd2;
        sin    = 1'b0;
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        tests_run++;
        if (q !== 8'h3C || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_start: got q=%h busy=%b done=%b expected q=3c busy=0 done=0", q, busy, done);
        end
        @(negedge clk);
        tests_run++;
        if (q !== 8'h3C || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_start_after: got q=%h busy=%b done=%b expected q=3c busy=0 done=0", q, busy, done);
        end
    endtask

    task automatic test_left_shift();
        exp_t e;
        int   bc;
        bit   ok;
        do_load(8'hA5);
        sb.push_back('{q: 8'h28, sout: 1'b1});
        issue_cmd(1'b0, 4'd3, 1'b0);
        wait_done(20, bc, ok);
        tests_run++;
        if (!ok || bc != 3) begin
            tests_failed++;
            $display("FAIL left_busy: got done_seen=%0d busy_cycles=%0d expected 1 3", ok, bc);
        end
        e = sb.pop_front();
        tests_run++;
        if (q !== e.q || sout !== e.sout) begin
            tests_failed++;
            $display("FAIL left_result: got q=%h sout=%b expected q=%h sout=%b", q, sout, e.q, e.sout);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL left_done_width: got done=%b expected 0", done);
        end
    endtask

    task automatic test_overlength_right();
        exp_t e;
        int   bc;
        bit   ok;
        do_load(8'h00);
        sb.push_back('{q: 8'hFF, sout: 1'b1});
        issue_cmd(1'b1, 4'd10, 1'b1);
        wait_done(30, bc, ok);
        tests_run++;
        if (!ok || bc != 10) begin
            tests_failed++;
            $display("FAIL over_busy: got done_seen=%0d busy_cycles=%0d expected 1 10", ok, bc);
        end
        e = sb.pop_front();
        tests_run++;
        if (q !== e.q || sout !== e.sout) begin
            tests_failed++;
            $display("FAIL over_result: got q=%h sout=%b expected q=%h sout=%b", q, sout, e.q, e.sout);
        end
    endtask

    task automatic test_zero_amount();
        do_load(8'h5A);
        issue_cmd(1'b0, 4'd0, 1'b0);
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h5A) begin
            tests_failed++;
            $display("FAIL zero_cmd: got done=%b busy=%b q=%h expected 1 0 5a", done, busy, q);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h5A) begin
            tests_failed++;
            $display("FAIL zero_after: got done=%b busy=%b q=%h expected 0 0 5a", done, busy, q);
        end
    endtask

    task automatic test_mid_reset();
        int dones;
        do_load(8'h5A);
        issue_cmd(1'b0, 4'd5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (q !== 8'hFF || busy !== 1'b0 || done !== 1'b0 || sout !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset: got q=%h busy=%b done=%b sout=%b expected ff 0 0 1", q, busy, done, sout);
        end
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1 || busy === 1'b1) dones++;
            @(negedge clk);
        end
        tests_run++;
        if (dones != 0) begin
            tests_failed++;
            $display("FAIL mid_reset_quiet: got %0d busy/done cycles expected 0", dones);
        end
    endtask

    task automatic test_ignore_during_shift();
        exp_t e;
        int   dones;
        do_load(8'h0F);
        sb.push_back('{q: 8'h7F, sout: 1'b0});
        issue_cmd(1'b0, 4'd3, 1'b1);
        // Retrigger, reload and change dir/amount while shifting
        start  = 1'b1;
        load   = 1'b1;
        din    = 8'h00;
        dir    = 1'b1;
        amount = 4'd7;
        @(negedge clk);
        start = 1'b0;
        load  = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    e = sb.pop_front();
                    tests_run++;
                    if (q !== e.q || sout !== e.sout) begin
                        tests_failed++;
                        $display("FAIL ignore_result: got q=%h sout=%b expected q=%h sout=%b", q, sout, e.q, e.sout);
                    end
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (dones != 1) begin
            tests_failed++;
            $display("FAIL ignore_done_count: got %0d expected 1", dones);
        end
    endtask

    task automatic test_back_to_back();
        exp_t             e;
        int               bc;
        bit               ok;
        logic [WIDTH-1:0] v;
        logic             d;
        logic             s;
        int               n;
        for (int k = 0; k < 6; k++) begin
            v = WIDTH'($urandom);
            d = 1'($urandom_range(1));
            s = 1'($urandom_range(1));
            n = int'($urandom_range(15, 1));
            do_load(v);
            sb.push_back(model(v, sout, d, n, s));
            issue_cmd(d, CNT_W'(n), s);
            wait_done(40, bc, ok);
            tests_run++;
            if (!ok || bc != n) begin
                tests_failed++;
                $display("FAIL b2b_busy[%0d]: got done_seen=%0d busy_cycles=%0d expected 1 %0d", k, ok, bc, n);
            end
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL b2b_scoreboard[%0d]: got empty queue expected one entry", k);
            end else begin
                e = sb.pop_front();
                tests_run++;
                if (q !== e.q || sout !== e.sout) begin
                    tests_failed++;
                    $display("FAIL b2b_result[%0d]: got q=%h sout=%b expected q=%h sout=%b", k, q, sout, e.q, e.sout);
                end
            end
        end
    endtask

`ifdef USR_ROTATE_EN
    task automatic test_rotate();
        exp_t e;
        int   bc;
        bit   ok;
        do_load(8'h81);
        sb.push_back('{q: 8'h03, sout: 1'b1});
        rot = 1'b1;
        issue_cmd(1'b0, 4'd1, 1'b0);
        rot = 1'b0;
        wait_done(10, bc, ok);
        e = sb.pop_front();
        tests_run++;
        if (!ok || q !== e.q || sout !== e.sout) begin
            tests_failed++;
            $display("FAIL rotate: got done_seen=%0d q=%h sout=%b expected 1 q=%h sout=%b", ok, q, sout, e.q, e.sout);
        end
    endtask
`endif

    initial begin
        rst    = 1'b1;
        load   = 1'b0;
        din    = '0;
        start  = 1'b0;
        dir    = 1'b0;
        amount = '0;
        sin    = 1'b0;
`ifdef USR_ROTATE_EN
        rot    = 1'b0;
`endif
        test_reset();
        test_load();
        test_left_shift();
        test_overlength_right();
        test_zero_amount();
        test_mid_reset();
        test_ignore_during_shift();
        test_back_to_back();
`ifdef USR_ROTATE_EN
        test_rotate();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
